// File: rtl/prach_hb1_sched.sv
// Front-end scheduler for the TDM hb1 half-band stage: pairs even/odd samples
// per channel, aligns frame sync, gates disabled channels and counts drops.
module prach_hb1_sched #(
    parameter int NUM_CH = 16,
    parameter int DW     = 16,
    parameter int CW     = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DW-1:0]     din_dq,
    input  logic              din_dv,
    input  logic [CW-1:0]     din_chn,
    input  logic              sync_in,
    input  logic [NUM_CH-1:0] ch_en,
    output logic [DW-1:0]     dout_dp1,
    output logic [DW-1:0]     dout_dp2,
    output logic              dout_dv,
    output logic [CW-1:0]     dout_chn,
    output logic              sync_out,
    output logic [15:0]       drop_cnt,
    output logic              err_chn
);

    localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0] phase_reg;
    logic [NUM_CH-1:0] phase_next;
    logic [NUM_CH-1:0] hit;
    logic [NUM_CH-1:0] phase_eff;

    logic [DW-1:0]     store_mem [NUM_CH];

    logic [IW-1:0]     chn_idx;
    logic              tag_ok;
    logic              chn_enabled;
    logic              sel_phase;
    logic              accept;
    logic              issue;
    logic              store_wr;
    logic              drop;
    logic [15:0]       drop_cnt_next;

    logic [DW-1:0]     dp1_reg;
    logic [DW-1:0]     dp2_reg;
    logic              dv_reg;
    logic [CW-1:0]     chn_reg;
    logic              sync_reg;
    logic [15:0]       drop_cnt_reg;
    logic              err_reg;

    assign chn_idx     = din_chn[IW-1:0];
    assign tag_ok      = ({1'b0, din_chn} < (CW+1)'(NUM_CH));
    assign chn_enabled = tag_ok & ch_en[chn_idx];

    // sync_in clears every phase before the same-cycle sample is looked at
    assign sel_phase   = phase_reg[chn_idx] & ~sync_in;

    assign accept      = din_dv & chn_enabled;
    assign issue       = accept & sel_phase;
    assign store_wr    = accept & ~sel_phase;
    assign drop        = din_dv & ~chn_enabled;

    assign drop_cnt_next = (drop && drop_cnt_reg != 16'hFFFF) ? drop_cnt_reg + 16'd1
                                                              : drop_cnt_reg;

    // Per-channel phase: toggles on an accepted sample, forced even on a
    // sample arriving while disabled, untouched by bad tags.
    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_phase
            assign hit[gi]        = din_dv & tag_ok & (chn_idx == IW'(gi));
            assign phase_eff[gi]  = phase_reg[gi] & ~sync_in;
            assign phase_next[gi] = hit[gi] ? (ch_en[gi] & ~phase_eff[gi])
                                            : phase_eff[gi];
        end
    endgenerate

    // Store holds the even sample; contents need no reset.
    always_ff @(posedge clk) begin
        if (store_wr) begin
            store_mem[chn_idx] <= din_dq;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_reg    <= '0;
            dp1_reg      <= '0;
            dp2_reg      <= '0;
            dv_reg       <= 1'b0;
            chn_reg      <= '0;
            sync_reg     <= 1'b0;
            drop_cnt_reg <= '0;
            err_reg      <= 1'b0;
        end else begin
            phase_reg    <= phase_next;
            dv_reg       <= issue;
            sync_reg     <= sync_in;
            err_reg      <= din_dv & ~tag_ok;
            drop_cnt_reg <= drop_cnt_next;
            if (issue) begin
                dp1_reg <= din_dq;
                dp2_reg <= store_mem[chn_idx];
                chn_reg <= din_chn;
            end
        end
    end

    assign dout_dp1 = dp1_reg;
    assign dout_dp2 = dp2_reg;
    assign dout_dv  = dv_reg;
    assign dout_chn = chn_reg;
    assign sync_out = sync_reg;
    assign drop_cnt = drop_cnt_reg;
    assign err_chn  = err_reg;

endmodule
